// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the cache/memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        I_FILL,
        D_FILL,
        D_WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/mem_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_buffer
// Description : BLOCKSIZE-word block register with indexed word write and a
//               synchronous clear. Word 0 occupies the most-significant slot.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fill_buffer #(
    parameter int BLOCKSIZE = 4,
    parameter int IDX_W     = $clog2(BLOCKSIZE)
) (
    input  logic                      clk,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [31:0]               i_wdata,
    output logic [BLOCKSIZE*32-1:0]   o_block
);

    for (genvar k = 0; k < BLOCKSIZE; k++) begin : g_word
        logic [31:0] r_word_q;
        logic [31:0] w_word_d;

        always_comb begin
            w_word_d = r_word_q;
            if (i_clr) begin
                w_word_d = '0;
            end else if (i_en && (i_idx == IDX_W'(k))) begin
                w_word_d = i_wdata;
            end
        end

        always_ff @(posedge clk) begin
            r_word_q <= w_word_d;
        end

        assign o_block[32*(BLOCKSIZE-k)-1 -: 32] = r_word_q;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one word-wide memory port between icache block fills
//               and dcache fills / write-through stores. Optional macro
//               MEM_ARB_ROUND_ROBIN_EN replaces fixed dcache priority with
//               last-grant round robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCKSIZE = 4,
    parameter int ADDRBITS  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRBITS-1:0]     i_addr,
    output logic [BLOCKSIZE*32-1:0] i_rdata,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRBITS-1:0]     d_addr,
    input  logic [31:0]             d_wdata,
    output logic [BLOCKSIZE*32-1:0] d_rdata,
    output logic                    d_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRBITS-1:0]     mem_addr,
    output logic [31:0]             mem_wd,
    input  logic [31:0]             mem_rd,
    input  logic                    mem_ack,
    output logic                    busy
);

    localparam int c_off   = $clog2(WORD_BYTES);
    localparam int c_cnt_w = $clog2(BLOCKSIZE);
    localparam int c_blk_w = BLOCKSIZE * 32;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLOCKSIZE - 1);

    arb_state_t                 r_state_q, w_state_d;
    grant_t                     r_gnt_q,   w_gnt_d;
    logic [c_cnt_w-1:0]         r_cnt_q,   w_cnt_d;
    logic [ADDRBITS-1:c_off]    r_addr_q,  w_addr_d;
    logic [31:0]                r_wd_q,    w_wd_d;
    logic [c_blk_w-1:0]         r_irdata_q, w_irdata_d;
    logic [c_blk_w-1:0]         r_drdata_q, w_drdata_d;
    logic                       w_pick_d;
    logic                       w_buf_en;
    logic [c_blk_w-1:0]         w_buf_block;
    logic [c_blk_w-1:0]         w_fill_block;
    logic                       w_unused;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t                     r_last_q, w_last_d;
`endif

    mem_fill_buffer #(
        .BLOCKSIZE (BLOCKSIZE),
        .IDX_W     (c_cnt_w)
    ) u_fill_buffer (
        .clk     (clk),
        .i_clr   (reset),
        .i_en    (w_buf_en),
        .i_idx   (r_cnt_q),
        .i_wdata (mem_rd),
        .o_block (w_buf_block)
    );

    // The final word lands in the last slot on the same edge the block is
    // published, so it is taken straight from mem_rd.
    assign w_fill_block = {w_buf_block[c_blk_w-1:32], mem_rd};
    assign w_unused     = ^{i_addr[c_off-1:0], d_addr[c_off-1:0], w_buf_block[31:0]};

    assign i_rdata = r_irdata_q;
    assign d_rdata = r_drdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= IDLE;
            r_gnt_q    <= GNT_I;
            r_cnt_q    <= '0;
            r_addr_q   <= '0;
            r_wd_q     <= '0;
            r_irdata_q <= '0;
            r_drdata_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_gnt_q    <= w_gnt_d;
            r_cnt_q    <= w_cnt_d;
            r_addr_q   <= w_addr_d;
            r_wd_q     <= w_wd_d;
            r_irdata_q <= w_irdata_d;
            r_drdata_q <= w_drdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        w_last_d = r_last_q;
        if ((r_state_q == IDLE) && (w_state_d != IDLE)) begin
            w_last_d = w_gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_q <= GNT_I;
        end else begin
            r_last_q <= w_last_d;
        end
    end
`endif

    always_comb begin
        w_state_d  = r_state_q;
        w_gnt_d    = r_gnt_q;
        w_cnt_d    = r_cnt_q;
        w_addr_d   = r_addr_q;
        w_wd_d     = r_wd_q;
        w_irdata_d = r_irdata_q;
        w_drdata_d = r_drdata_q;
        w_buf_en   = 1'b0;
        w_pick_d   = 1'b0;
        case (r_state_q)
            IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w_pick_d = d_req && (!i_req || (r_last_q == GNT_I));
`else
                w_pick_d = d_req;
`endif
                w_cnt_d = '0;
                if (w_pick_d) begin
                    w_gnt_d   = GNT_D;
                    w_addr_d  = d_addr[ADDRBITS-1:c_off];
                    w_wd_d    = d_wdata;
                    w_state_d = d_we ? D_WRITE : D_FILL;
                end else if (i_req) begin
                    w_gnt_d   = GNT_I;
                    w_addr_d  = i_addr[ADDRBITS-1:c_off];
                    w_state_d = I_FILL;
                end
            end
            I_FILL, D_FILL: begin
                if (mem_ack) begin
                    w_buf_en = 1'b1;
                    w_cnt_d  = r_cnt_q + 1'b1;
                    if (r_cnt_q == c_last) begin
                        w_state_d = DONE;
                        if (r_gnt_q == GNT_I) begin
                            w_irdata_d = w_fill_block;
                        end else begin
                            w_drdata_d = w_fill_block;
                        end
                    end
                end
            end
            D_WRITE: begin
                if (mem_ack) begin
                    w_state_d = DONE;
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        busy     = (r_state_q != IDLE);
        case (r_state_q)
            I_FILL, D_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr_q[ADDRBITS-1:c_off+c_cnt_w], r_cnt_q, {c_off{1'b0}}};
            end
            D_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {r_addr_q, {c_off{1'b0}}};
                mem_wd   = r_wd_q;
            end
            DONE: begin
                i_done = (r_gnt_q == GNT_I);
                d_done = (r_gnt_q == GNT_D);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
